// File: rtl/stack_sequencer_pkg.sv
// Shared stack-operation encodings and sequencer state type, reused by the control unit.
package stack_sequencer_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WRITE,
        ST_INC,
        ST_DEC,
        ST_READ,
        ST_CAPT,
        ST_SETSP,
        ST_DONE,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: steps the SP register and data memory through PUSH, POP and LOAD-SP,
// with registered Moore controls and a done/fault completion pulse.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int WORD_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5,
    parameter int STACK_BASE    = 0,
    parameter int STACK_LIMIT   = 31
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     req,
    input  logic [1:0]               op,
    input  logic [WORD_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    output logic                     ready,
    output logic                     done,
    output logic                     fault,
    output logic [WORD_WIDTH-1:0]    dout,
    input  logic [ADDRESS_WIDTH-1:0] sp_value,
    output logic                     sp_din,
    output logic                     sp_inc,
    output logic                     sp_dec,
    output logic                     sp_aout,
    output logic                     abus_oe,
    output logic [ADDRESS_WIDTH-1:0] abus_out,
    output logic                     mem_wr,
    output logic                     mem_rd,
    output logic [WORD_WIDTH-1:0]    mem_wdata,
    input  logic [WORD_WIDTH-1:0]    mem_rdata
);

    localparam logic [ADDRESS_WIDTH-1:0] LP_BASE  = ADDRESS_WIDTH'(STACK_BASE);
    localparam logic [ADDRESS_WIDTH-1:0] LP_LIMIT = ADDRESS_WIDTH'(STACK_LIMIT);

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_accept;
    logic                     r_ready, r_done, r_fault;
    logic                     r_spDin, r_spInc, r_spDec, r_spAout, r_abusOe;
    logic                     r_memWr, r_memRd;
    logic                     w_ready, w_done, w_fault;
    logic                     w_spDin, w_spInc, w_spDec, w_spAout, w_abusOe;
    logic                     w_memWr, w_memRd;
    logic [WORD_WIDTH-1:0]    r_wdata, r_dout;
    logic [ADDRESS_WIDTH-1:0] r_loadAddr;

    assign w_accept = (r_state == ST_IDLE) && req && r_ready;

    // State, control outputs and data latches; controls are registered from the next state
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_spDin    <= 1'b0;
            r_spInc    <= 1'b0;
            r_spDec    <= 1'b0;
            r_spAout   <= 1'b0;
            r_abusOe   <= 1'b0;
            r_memWr    <= 1'b0;
            r_memRd    <= 1'b0;
            r_wdata    <= '0;
            r_dout     <= '0;
            r_loadAddr <= '0;
        end else begin
            r_state  <= w_next;
            r_ready  <= w_ready;
            r_done   <= w_done;
            r_fault  <= w_fault;
            r_spDin  <= w_spDin;
            r_spInc  <= w_spInc;
            r_spDec  <= w_spDec;
            r_spAout <= w_spAout;
            r_abusOe <= w_abusOe;
            r_memWr  <= w_memWr;
            r_memRd  <= w_memRd;
            if (w_accept) begin
                r_wdata    <= din;
                r_loadAddr <= load_addr;
            end
            if (r_state == ST_CAPT) begin
                r_dout <= mem_rdata;
            end
        end
    end

    // Range checks use the SP value seen at accept
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (op)
                        OP_PUSH: w_next = (sp_value == LP_LIMIT) ? ST_FAULT : ST_WRITE;
                        OP_POP:  w_next = (sp_value == LP_BASE)  ? ST_FAULT : ST_DEC;
                        OP_LOAD: w_next = ST_SETSP;
                        default: w_next = ST_FAULT;
                    endcase
                end
            end
            ST_WRITE: w_next = ST_INC;
            ST_INC:   w_next = ST_DONE;
            ST_DEC:   w_next = ST_READ;
            ST_READ:  w_next = ST_CAPT;
            ST_CAPT:  w_next = ST_DONE;
            ST_SETSP: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            ST_FAULT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready  = (w_next == ST_IDLE);
        w_done   = (w_next == ST_DONE) || (w_next == ST_FAULT);
        w_fault  = (w_next == ST_FAULT);
        w_spDin  = (w_next == ST_SETSP);
        w_spInc  = (w_next == ST_INC);
        w_spDec  = (w_next == ST_DEC);
        w_spAout = (w_next == ST_WRITE) || (w_next == ST_READ);
        w_abusOe = (w_next == ST_SETSP);
        w_memWr  = (w_next == ST_WRITE);
        w_memRd  = (w_next == ST_READ);
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign fault     = r_fault;
    assign dout      = r_dout;
    assign sp_din    = r_spDin;
    assign sp_inc    = r_spInc;
    assign sp_dec    = r_spDec;
    assign sp_aout   = r_spAout;
    assign abus_oe   = r_abusOe;
    assign abus_out  = r_loadAddr;
    assign mem_wr    = r_memWr;
    assign mem_rd    = r_memRd;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed boundary cases then random ops against a stack model,
// with a behavioural SP register and memory on the address bus.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       req = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] din = 8'h00;
    logic [4:0] load_addr = 5'd0;
    logic       ready, done, fault;
    logic [7:0] dout;
    logic       sp_din, sp_inc, sp_dec, sp_aout, abus_oe;
    logic [4:0] abus_out;
    logic       mem_wr, mem_rd;
    logic [7:0] mem_wdata;
    logic [7:0] memRdata;

    logic       envInit = 1'b1;
    logic [4:0] envSp;
    logic [7:0] envMem [0:31];
    logic [4:0] abus;
    int         wrCount, rdCount;

    logic [4:0] refSp;
    logic [7:0] refMem [0:31];
    logic [7:0] refDout;
    int         checks = 0;
    int         failures = 0;
    int         lastWait;

    stack_sequencer dut (
        .CLK(CLK), .CLR(CLR), .req(req), .op(op), .din(din), .load_addr(load_addr),
        .ready(ready), .done(done), .fault(fault), .dout(dout), .sp_value(envSp),
        .sp_din(sp_din), .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_aout(sp_aout),
        .abus_oe(abus_oe), .abus_out(abus_out), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_wdata(mem_wdata), .mem_rdata(memRdata)
    );

    always #5 CLK = ~CLK;

    assign abus = sp_aout ? envSp : (abus_oe ? abus_out : 5'd0);

    // SP register and memory as seen on the bus; the SP register is never cleared by CLR
    always @(posedge CLK) begin
        if (envInit) begin
            envSp <= 5'd0;
            for (int i = 0; i < 32; i++) envMem[i] <= 8'(i * 7 + 3);
            memRdata <= 8'h00;
            wrCount  <= 0;
            rdCount  <= 0;
        end else begin
            if (sp_inc) envSp <= envSp + 5'd1;
            else if (sp_dec) envSp <= envSp - 5'd1;
            else if (sp_din) envSp <= abus;
            if (mem_wr) envMem[abus] <= mem_wdata;
            if (mem_rd) memRdata <= envMem[abus];
            wrCount <= wrCount + int'(mem_wr);
            rdCount <= rdCount + int'(mem_rd);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 20) begin
            @(negedge CLK);
            cycles++;
        end
    endtask

    // Issue one op from a negedge and follow it to completion against the stack model
    task automatic applyStimulus(input logic [1:0] opv, input logic [7:0] dv, input logic [4:0] av,
                                 input bit holdReq, input string tag);
        int         lat, waitCyc, wr0, rd0, expLat, expWr, expRd;
        logic [4:0] sp0;
        logic       expFault;
        bit         sawDone;
        req = 1'b1; op = opv; din = dv; load_addr = av;
        waitReady(waitCyc);
        lastWait = waitCyc;
        checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
        if (ready !== 1'b1) begin
            req = 1'b0;
            return;
        end
        sp0 = refSp; wr0 = wrCount; rd0 = rdCount;
        expWr = 0; expRd = 0; expFault = 1'b0; expLat = 1;
        case (opv)
            OP_PUSH: if (refSp == 5'd31) expFault = 1'b1;
                     else begin refMem[refSp] = dv; refSp = refSp + 5'd1; expLat = 3; expWr = 1; end
            OP_POP:  if (refSp == 5'd0) expFault = 1'b1;
                     else begin refSp = refSp - 5'd1; refDout = refMem[refSp]; expLat = 4; expRd = 1; end
            OP_LOAD: begin refSp = av; expLat = 2; end
            default: expFault = 1'b1;
        endcase
        @(posedge CLK);
        lat = 0; sawDone = 1'b0;
        while (!sawDone && lat < 10) begin
            @(negedge CLK);
            lat++;
            if (!holdReq) req = 1'b0;
            checkOutput({tag, "_spOneHot"}, 32'($countones({sp_din, sp_inc, sp_dec}) <= 1), 32'd1);
            checkOutput({tag, "_busExcl"}, 32'(!(sp_aout && abus_oe)), 32'd1);
            checkOutput({tag, "_busyReady"}, 32'(ready), 32'd0);
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput({tag, "_done"}, 32'(sawDone), 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_fault"}, 32'(fault), 32'(expFault));
        checkOutput({tag, "_sp"}, 32'(envSp), 32'(refSp));
        checkOutput({tag, "_dout"}, 32'(dout), 32'(refDout));
        checkOutput({tag, "_wrCount"}, 32'(wrCount - wr0), 32'(expWr));
        checkOutput({tag, "_rdCount"}, 32'(rdCount - rd0), 32'(expRd));
        if (expWr != 0) checkOutput({tag, "_mem"}, 32'(envMem[sp0]), 32'(refMem[sp0]));
    endtask

    initial begin
        int         w;
        int         r;
        logic [4:0] a;
        refSp = 5'd0;
        refDout = 8'h00;
        for (int i = 0; i < 32; i++) refMem[i] = 8'(i * 7 + 3);
        repeat (3) @(negedge CLK);
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_ctrl", 32'({done, fault, sp_din, sp_inc, sp_dec, sp_aout, abus_oe, mem_wr, mem_rd}), 32'd0);
        checkOutput("rst_data", 32'({dout, mem_wdata, abus_out}), 32'd0);
        CLR = 1'b0;
        envInit = 1'b0;
        @(negedge CLK);

        applyStimulus(OP_PUSH, 8'hA5, 5'd0, 1'b0, "t1Push");
        checkOutput("t1Mem0", 32'(envMem[0]), 32'h0A5);
        applyStimulus(OP_POP, 8'h00, 5'd0, 1'b0, "t2Pop");
        checkOutput("t2Dout", 32'(dout), 32'h0A5);
        applyStimulus(OP_POP, 8'h00, 5'd0, 1'b0, "t3PopEmpty");
        applyStimulus(OP_LOAD, 8'h00, 5'd31, 1'b0, "t4Load");
        applyStimulus(OP_PUSH, 8'h5A, 5'd0, 1'b0, "t4PushFull");

        applyStimulus(OP_LOAD, 8'h00, 5'd0, 1'b0, "t5Load");
        applyStimulus(OP_PUSH, 8'h11, 5'd0, 1'b1, "t5PushHeld");
        applyStimulus(OP_PUSH, 8'h22, 5'd0, 1'b0, "t5PushNext");
        checkOutput("t5BackToBack", 32'(lastWait), 32'd1);

        waitReady(w);
        req = 1'b1; op = OP_POP;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0;
        checkOutput("t6Dec", 32'(sp_dec), 32'd1);
        @(negedge CLK);
        checkOutput("t6Read", 32'(mem_rd), 32'd1);
        CLR = 1'b1;
        #1;
        refSp = refSp - 5'd1;
        refDout = 8'h00;
        checkOutput("t6AsyncCtrl", 32'({done, fault, sp_din, sp_inc, sp_dec, sp_aout, abus_oe, mem_wr, mem_rd}), 32'd0);
        checkOutput("t6AsyncData", 32'({dout, mem_wdata}), 32'd0);
        checkOutput("t6AsyncReady", 32'(ready), 32'd1);
        @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);
        checkOutput("t6ReadyAfter", 32'(ready), 32'd1);
        checkOutput("t6SpLeft", 32'(envSp), 32'(refSp));
        applyStimulus(OP_RSVD, 8'h00, 5'd0, 1'b0, "t6Reserved");

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            a = 5'($urandom);
            if ($urandom_range(0, 2) == 0) a = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
            if (r < 4)      applyStimulus(OP_PUSH, 8'($urandom), a, 1'($urandom), "rndPush");
            else if (r < 7) applyStimulus(OP_POP, 8'($urandom), a, 1'($urandom), "rndPop");
            else if (r < 9) applyStimulus(OP_LOAD, 8'($urandom), a, 1'($urandom), "rndLoad");
            else            applyStimulus(OP_RSVD, 8'($urandom), a, 1'($urandom), "rndRsvd");
        end
        req = 1'b0;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
